holy_axi_arbiter: RTL and testbench
===================================

Name: holy_axi_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter between the instruction cache and data cache and the single external memory port.
- Each cache issues one full-burst transaction at a time: one read or one write-back of CACHE_SIZE words.
- Arbiter grants one cache, holds that grant until the transaction completes, then re-arbitrates.
- Non-granted cache is stalled by withheld ready/valid handshakes.

Parameters:
- I_ID, 4'b0000, AXI ID driven on awid/arid when the instruction cache is granted.
- D_ID, 4'b0001, AXI ID driven on awid/arid when the data cache is granted.

Ports:
- clk  input  1  single clock; CPU, cache and AXI logic all on this domain.
- rst_n  input  1  asynchronous active-low reset.
- s_axi_instr  axi_if.slave  -  instruction cache AXI port.
- s_axi_data  axi_if.slave  -  data cache AXI port.
- m_axi  axi_if.master  -  external memory AXI port.
- grant  output  2  one-hot current owner: 2'b01 instr, 2'b10 data, 2'b00 none.
- busy  output  1  high while any transaction is owned.

Behaviour:
- Request from a cache: awvalid | arvalid on its slave port.
- FSM states:
  - IDLE
  - SERVE_RD: read owned
  - SERVE_WR_ADDR: write address phase
  - SERVE_WR_DATA: write data phase
  - SERVE_WR_RESP: write response phase
- Registers: owner (1 bit), state.
- Reset (async, rst_n low): state=IDLE, grant=0, busy=0, all m_axi valids/readies 0, all slave readies/valids 0.
- IDLE:
  - Choose owner (see priority). Registered; owner's request is forwarded starting the next cycle, giving 1 cycle of arbitration latency.
  - A cache asserting both awvalid and arvalid is served as a write first.
  - No request: remain IDLE.
- Forwarding while owned:
  - Owner's aw*, w*, ar* channels and bready/rready are muxed to m_axi.
  - m_axi aw/w/ar readies and r/b responses are routed back to the owner only.
  - awid/arid are overridden with I_ID/D_ID.
  - awlen/arlen, size, burst and wstrb pass through unchanged.
- Non-owner: awready, wready, arready, bvalid, rvalid all 0; its request stays pending.
- Write sequence:
  - SERVE_WR_ADDR → SERVE_WR_DATA on awvalid & awready.
  - SERVE_WR_DATA → SERVE_WR_RESP on wvalid & wready & wlast.
  - SERVE_WR_RESP → IDLE on bvalid & bready. bresp passes through unmodified, including errors.
- Read sequence: SERVE_RD → IDLE on rvalid & rready & rlast.
- Outside the phase-correct state, the corresponding m_axi valid is forced 0. Example: wvalid is gated to 0 in SERVE_WR_ADDR even if the cache raises it early.
- Back-to-back transactions: at least 1 IDLE cycle between them. A cache's write-back followed by its refill read is two separate arbitrations; the other cache may be served in between.
- rid/bid mismatch with the owner ID: ignored; routing is by owner only, since there is one outstanding transaction.
- A request dropped mid-transaction is protocol-illegal; the arbiter stays in state until the completion condition.
- grant and busy are combinational from the registered state/owner: busy = (state != IDLE).

Optional Feature:
- Macro: HOLY_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, the cache NOT served last wins. The last-served register resets to instr, so data wins the first tie.
- Undefined: fixed priority, data cache always wins ties. The last-served register is not instantiated.

Test Plan:
- Instr only, read burst arlen=127: araddr 0x0000_1000 on m_axi one cycle after arvalid; arid=I_ID; 128 beats routed to instr; rlast beat returns to IDLE; data port sees rvalid=0 throughout.
- Data write-back: aw at 0x0000_2000, 128 beats, bresp=OKAY. Expect awid=D_ID, exactly 128 wready beats forwarded, bvalid to data cache only, busy low the cycle after the b handshake.
- Simultaneous requests, fixed priority: instr read and data read both at cycle 0. Data served first; instr arvalid reaches m_axi only after the data rlast plus 1 IDLE cycle.
- HOLY_ARB_ROUND_ROBIN_EN: three consecutive simultaneous-request rounds give grant order data, instr, data.
- Reset mid-burst: rst_n low at beat 40 of a read. Same cycle: grant=0, busy=0, m_axi rready=0. After release: IDLE, and a fresh request is served normally.
- Early wvalid: data cache asserts wvalid together with awvalid and awready is held low 5 cycles. m_axi wvalid stays 0 until the aw handshake, then the data phase proceeds.

Source files
------------

// File: rtl/holy_axi_arbiter_if.sv
// AXI4 bus bundle shared by the cache ports and the external memory port.
interface holy_axi_arbiter_if;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/holy_axi_arbiter.sv
// Two-cache to one-memory AXI4 arbiter; one burst owned at a time.
// HOLY_ARB_ROUND_ROBIN_EN: tie goes to the cache not served last (else data cache wins ties).
module holy_axi_arbiter #(
    parameter logic [3:0] I_ID = 4'b0000,
    parameter logic [3:0] D_ID = 4'b0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    holy_axi_arbiter_if.slave    s_axi_instr,
    holy_axi_arbiter_if.slave    s_axi_data,
    holy_axi_arbiter_if.master   m_axi,
    output logic [1:0]           grant,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_RD,
        SERVE_WR_ADDR,
        SERVE_WR_DATA,
        SERVE_WR_RESP
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;   // 1 = data cache
    logic   req_i, req_d, pick_d;
    logic   in_rd, in_wa, in_wd, in_wb;
    logic   unused_ids;

    assign req_i = s_axi_instr.awvalid | s_axi_instr.arvalid;
    assign req_d = s_axi_data.awvalid  | s_axi_data.arvalid;

`ifdef HOLY_ARB_ROUND_ROBIN_EN
    logic last_d;

    // Remember who won the last arbitration so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (req_i | req_d)) begin
            last_d <= pick_d;
        end
    end

    assign pick_d = req_d & (~req_i | ~last_d);
`else
    assign pick_d = req_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (req_i | req_d) begin
                    owner_nxt = pick_d;
                    // A cache raising both awvalid and arvalid is served as a write first.
                    if (pick_d ? s_axi_data.awvalid : s_axi_instr.awvalid) begin
                        state_nxt = SERVE_WR_ADDR;
                    end else begin
                        state_nxt = SERVE_RD;
                    end
                end
            end
            SERVE_RD: begin
                if (m_axi.rvalid & m_axi.rready & m_axi.rlast) state_nxt = IDLE;
            end
            SERVE_WR_ADDR: begin
                if (m_axi.awvalid & m_axi.awready) state_nxt = SERVE_WR_DATA;
            end
            SERVE_WR_DATA: begin
                if (m_axi.wvalid & m_axi.wready & m_axi.wlast) state_nxt = SERVE_WR_RESP;
            end
            SERVE_WR_RESP: begin
                if (m_axi.bvalid & m_axi.bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_rd = (state == SERVE_RD);
    assign in_wa = (state == SERVE_WR_ADDR);
    assign in_wd = (state == SERVE_WR_DATA);
    assign in_wb = (state == SERVE_WR_RESP);

    assign busy  = (state != IDLE);
    assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

    // Owner's request toward memory; valids only pass in their own phase.
    assign m_axi.awid    = owner ? D_ID : I_ID;
    assign m_axi.awaddr  = owner ? s_axi_data.awaddr  : s_axi_instr.awaddr;
    assign m_axi.awlen   = owner ? s_axi_data.awlen   : s_axi_instr.awlen;
    assign m_axi.awsize  = owner ? s_axi_data.awsize  : s_axi_instr.awsize;
    assign m_axi.awburst = owner ? s_axi_data.awburst : s_axi_instr.awburst;
    assign m_axi.awvalid = in_wa & (owner ? s_axi_data.awvalid : s_axi_instr.awvalid);

    assign m_axi.wdata   = owner ? s_axi_data.wdata   : s_axi_instr.wdata;
    assign m_axi.wstrb   = owner ? s_axi_data.wstrb   : s_axi_instr.wstrb;
    assign m_axi.wlast   = owner ? s_axi_data.wlast   : s_axi_instr.wlast;
    assign m_axi.wvalid  = in_wd & (owner ? s_axi_data.wvalid : s_axi_instr.wvalid);

    assign m_axi.bready  = in_wb & (owner ? s_axi_data.bready : s_axi_instr.bready);

    assign m_axi.arid    = owner ? D_ID : I_ID;
    assign m_axi.araddr  = owner ? s_axi_data.araddr  : s_axi_instr.araddr;
    assign m_axi.arlen   = owner ? s_axi_data.arlen   : s_axi_instr.arlen;
    assign m_axi.arsize  = owner ? s_axi_data.arsize  : s_axi_instr.arsize;
    assign m_axi.arburst = owner ? s_axi_data.arburst : s_axi_instr.arburst;
    assign m_axi.arvalid = in_rd & (owner ? s_axi_data.arvalid : s_axi_instr.arvalid);

    assign m_axi.rready  = in_rd & (owner ? s_axi_data.rready : s_axi_instr.rready);

    // Memory responses routed back to the owner only; payloads are shared.
    assign s_axi_instr.awready = in_wa & ~owner & m_axi.awready;
    assign s_axi_instr.wready  = in_wd & ~owner & m_axi.wready;
    assign s_axi_instr.bvalid  = in_wb & ~owner & m_axi.bvalid;
    assign s_axi_instr.arready = in_rd & ~owner & m_axi.arready;
    assign s_axi_instr.rvalid  = in_rd & ~owner & m_axi.rvalid;

    assign s_axi_data.awready  = in_wa & owner & m_axi.awready;
    assign s_axi_data.wready   = in_wd & owner & m_axi.wready;
    assign s_axi_data.bvalid   = in_wb & owner & m_axi.bvalid;
    assign s_axi_data.arready  = in_rd & owner & m_axi.arready;
    assign s_axi_data.rvalid   = in_rd & owner & m_axi.rvalid;

    assign s_axi_instr.bid   = m_axi.bid;
    assign s_axi_instr.bresp = m_axi.bresp;
    assign s_axi_instr.rid   = m_axi.rid;
    assign s_axi_instr.rdata = m_axi.rdata;
    assign s_axi_instr.rresp = m_axi.rresp;
    assign s_axi_instr.rlast = m_axi.rlast;

    assign s_axi_data.bid    = m_axi.bid;
    assign s_axi_data.bresp  = m_axi.bresp;
    assign s_axi_data.rid    = m_axi.rid;
    assign s_axi_data.rdata  = m_axi.rdata;
    assign s_axi_data.rresp  = m_axi.rresp;
    assign s_axi_data.rlast  = m_axi.rlast;

    // Cache-side IDs are replaced by I_ID/D_ID toward memory.
    assign unused_ids = ^{s_axi_instr.awid, s_axi_instr.arid, s_axi_data.awid, s_axi_data.arid};

endmodule

// File: tb/tb_holy_axi_arbiter.sv
// Self-checking bench for holy_axi_arbiter: cache agents, a memory responder and a transaction-level model.
module tb_holy_axi_arbiter;

`ifdef HOLY_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [7:0]  len;
        bit          early_w;
    } txn_t;

    logic clk;
    logic rst_n;
    logic [1:0] grant;
    logic       busy;

    holy_axi_arbiter_if instr_bus ();
    holy_axi_arbiter_if data_bus ();
    holy_axi_arbiter_if mem_bus ();

    holy_axi_arbiter #(.I_ID(4'b0000), .D_ID(4'b0001)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axi_instr(instr_bus),
        .s_axi_data (data_bus),
        .m_axi      (mem_bus),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // cache agents (index 0 = instr, 1 = data)
    txn_t cq0[$];
    txn_t cq1[$];
    txn_t cur[2];
    bit   act[2];
    int   ph[2];
    int   beat[2];
    bit   awv[2], wv[2], arv[2], bre[2], rre[2];

    // memory responder
    bit          m_act, m_wr, m_resp, m_rvh;
    int          m_beat, aw_seen, aw_hold;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic [1:0]  m_bresp;
    bit          m_awr, m_wrd, m_arr, m_bv, m_rv;

    // reference model: who owns the memory port and who was served last
    bit         e_busy, e_own, e_last, prev_busy;
    logic [1:0] glog[$];

    function automatic logic [3:0] id_of(input bit c);
        return c ? 4'b0001 : 4'b0000;
    endfunction

    function automatic logic [4:0] srdy(input int c);
        if (c == 0)
            return {instr_bus.awready, instr_bus.wready, instr_bus.arready, instr_bus.bvalid, instr_bus.rvalid};
        return {data_bus.awready, data_bus.wready, data_bus.arready, data_bus.bvalid, data_bus.rvalid};
    endfunction

    task automatic clear_state();
        cq0.delete();
        cq1.delete();
        for (int c = 0; c < 2; c++) begin
            act[c] = 1'b0; ph[c] = 0; beat[c] = 0;
        end
        m_act = 1'b0; m_wr = 1'b0; m_resp = 1'b0; m_rvh = 1'b0;
        m_beat = 0; aw_seen = 0; aw_hold = 0;
        m_addr = '0; m_len = '0; m_bresp = '0;
        e_busy = 1'b0; e_own = 1'b0; e_last = 1'b0; prev_busy = 1'b0;
        glog.delete();
    endtask

    task automatic drive_all();
        for (int c = 0; c < 2; c++) begin
            if (!act[c]) begin
                if (c == 0 && cq0.size() > 0) begin cur[0] = cq0.pop_front(); act[0] = 1'b1; end
                if (c == 1 && cq1.size() > 0) begin cur[1] = cq1.pop_front(); act[1] = 1'b1; end
                ph[c] = 0; beat[c] = 0;
            end
            awv[c] = 1'b0; wv[c] = 1'b0; arv[c] = 1'b0; bre[c] = 1'b0; rre[c] = 1'b0;
            if (act[c]) begin
                if (cur[c].is_wr) begin
                    case (ph[c])
                        0: begin awv[c] = 1'b1; wv[c] = cur[c].early_w; end
                        1: wv[c] = 1'b1;
                        default: bre[c] = 1'b1;
                    endcase
                end else begin
                    if (ph[c] == 0) arv[c] = 1'b1;
                    else rre[c] = ($urandom % 4) != 0;
                end
            end
        end
        instr_bus.awid = 4'hF; instr_bus.awaddr = cur[0].addr; instr_bus.awlen = cur[0].len;
        instr_bus.awsize = 3'd2; instr_bus.awburst = 2'b01; instr_bus.awvalid = awv[0];
        instr_bus.wdata = cur[0].addr + 32'(beat[0]); instr_bus.wstrb = 4'(beat[0]);
        instr_bus.wlast = (beat[0] == int'(cur[0].len)); instr_bus.wvalid = wv[0]; instr_bus.bready = bre[0];
        instr_bus.arid = 4'hE; instr_bus.araddr = cur[0].addr; instr_bus.arlen = cur[0].len;
        instr_bus.arsize = 3'd2; instr_bus.arburst = 2'b01; instr_bus.arvalid = arv[0]; instr_bus.rready = rre[0];

        data_bus.awid = 4'hF; data_bus.awaddr = cur[1].addr; data_bus.awlen = cur[1].len;
        data_bus.awsize = 3'd2; data_bus.awburst = 2'b01; data_bus.awvalid = awv[1];
        data_bus.wdata = cur[1].addr + 32'(beat[1]); data_bus.wstrb = 4'(beat[1]);
        data_bus.wlast = (beat[1] == int'(cur[1].len)); data_bus.wvalid = wv[1]; data_bus.bready = bre[1];
        data_bus.arid = 4'hE; data_bus.araddr = cur[1].addr; data_bus.arlen = cur[1].len;
        data_bus.arsize = 3'd2; data_bus.arburst = 2'b01; data_bus.arvalid = arv[1]; data_bus.rready = rre[1];

        m_arr = !m_act && (($urandom % 4) != 0);
        m_awr = !m_act && (aw_seen >= aw_hold) && (($urandom % 4) != 0);
        m_wrd = m_act && m_wr && !m_resp && (($urandom % 4) != 0);
        m_bv  = m_act && m_wr && m_resp;
        m_rv  = m_act && !m_wr && (m_rvh || (($urandom % 4) != 0));
        mem_bus.awready = m_awr; mem_bus.wready = m_wrd; mem_bus.arready = m_arr;
        mem_bus.bvalid = m_bv; mem_bus.bresp = m_bresp; mem_bus.bid = 4'h0;
        mem_bus.rvalid = m_rv; mem_bus.rdata = m_addr + 32'(m_beat);
        mem_bus.rlast = (m_beat == int'(m_len)); mem_bus.rresp = 2'b00; mem_bus.rid = 4'h0;
    endtask

    task automatic check_all();
        logic [1:0] eg;
        logic [4:0] ectl, actl, erdy, ardy;
        int o;
        o  = int'(e_own);
        eg = e_busy ? (e_own ? 2'b10 : 2'b01) : 2'b00;
        n_checks++;
        if ({grant, busy} !== {eg, e_busy}) begin
            n_errors++;
            $display("FAIL grant_busy t=%0t got grant=%b busy=%b want grant=%b busy=%b", $time, grant, busy, eg, e_busy);
        end
        ectl = e_busy ? {awv[o], wv[o] && ph[o] >= 1, arv[o], bre[o], rre[o]} : 5'b0;
        actl = {mem_bus.awvalid, mem_bus.wvalid, mem_bus.arvalid, mem_bus.bready, mem_bus.rready};
        n_checks++;
        if (actl !== ectl) begin
            n_errors++;
            $display("FAIL m_axi_ctl t=%0t got aw/w/ar/b/r=%b want %b", $time, actl, ectl);
        end
        for (int c = 0; c < 2; c++) begin
            erdy = 5'b0;
            if (e_busy && c == o && act[c]) begin
                if (cur[c].is_wr)
                    erdy = {ph[c] == 0 && m_awr, ph[c] == 1 && m_wrd, 1'b0, ph[c] == 2 && m_bv, 1'b0};
                else
                    erdy = {1'b0, 1'b0, ph[c] == 0 && m_arr, 1'b0, m_rv};
            end
            ardy = srdy(c);
            n_checks++;
            if (ardy !== erdy) begin
                n_errors++;
                $display("FAIL cache%0d_route t=%0t got awr/wr/arr/bv/rv=%b want %b", c, $time, ardy, erdy);
            end
        end
    endtask

    task automatic update_all();
        bit done, pi, pd, w;
        done = (mem_bus.rvalid && mem_bus.rready && mem_bus.rlast) || (mem_bus.bvalid && mem_bus.bready);
        if (!prev_busy && busy) glog.push_back(grant);
        prev_busy = busy;

        // memory side
        if (mem_bus.awvalid && !m_awr) aw_seen++;
        if (!m_act) begin
            if (mem_bus.arvalid && m_arr) begin
                n_checks++;
                if ({mem_bus.arid, mem_bus.araddr, mem_bus.arlen, mem_bus.arsize, mem_bus.arburst} !==
                    {id_of(e_own), cur[e_own].addr, cur[e_own].len, 3'd2, 2'b01}) begin
                    n_errors++;
                    $display("FAIL ar_fwd got id=%h addr=%h len=%0d want id=%h addr=%h len=%0d", mem_bus.arid,
                             mem_bus.araddr, mem_bus.arlen, id_of(e_own), cur[e_own].addr, cur[e_own].len);
                end
                m_act = 1'b1; m_wr = 1'b0; m_addr = mem_bus.araddr; m_len = mem_bus.arlen; m_beat = 0; m_rvh = 1'b0;
            end else if (mem_bus.awvalid && m_awr) begin
                n_checks++;
                if ({mem_bus.awid, mem_bus.awaddr, mem_bus.awlen, mem_bus.awsize, mem_bus.awburst} !==
                    {id_of(e_own), cur[e_own].addr, cur[e_own].len, 3'd2, 2'b01}) begin
                    n_errors++;
                    $display("FAIL aw_fwd got id=%h addr=%h len=%0d want id=%h addr=%h len=%0d", mem_bus.awid,
                             mem_bus.awaddr, mem_bus.awlen, id_of(e_own), cur[e_own].addr, cur[e_own].len);
                end
                m_act = 1'b1; m_wr = 1'b1; m_resp = 1'b0; m_addr = mem_bus.awaddr; m_len = mem_bus.awlen;
                m_beat = 0; aw_seen = 0;
            end
        end else if (!m_wr) begin
            if (m_rv && mem_bus.rready) begin
                if (m_beat == int'(m_len)) m_act = 1'b0;
                else m_beat++;
                m_rvh = 1'b0;
            end else if (m_rv) begin
                m_rvh = 1'b1;
            end
        end else if (!m_resp) begin
            if (m_wrd && mem_bus.wvalid) begin
                n_checks++;
                if ({mem_bus.wdata, mem_bus.wstrb, mem_bus.wlast} !==
                    {m_addr + 32'(m_beat), 4'(m_beat), m_beat == int'(m_len)}) begin
                    n_errors++;
                    $display("FAIL w_fwd beat=%0d got data=%h strb=%h last=%b want data=%h last=%b", m_beat,
                             mem_bus.wdata, mem_bus.wstrb, mem_bus.wlast, m_addr + 32'(m_beat), m_beat == int'(m_len));
                end
                if (m_beat == int'(m_len)) begin
                    m_resp = 1'b1; m_bresp = 2'($urandom_range(0, 3));
                end else begin
                    m_beat++;
                end
            end
        end else if (mem_bus.bready) begin
            m_act = 1'b0;
        end

        // cache side
        for (int c = 0; c < 2; c++) begin
            logic [4:0] r;
            logic [31:0] rd;
            logic [1:0]  br;
            logic        rl;
            r  = srdy(c);
            rd = (c == 0) ? instr_bus.rdata : data_bus.rdata;
            rl = (c == 0) ? instr_bus.rlast : data_bus.rlast;
            br = (c == 0) ? instr_bus.bresp : data_bus.bresp;
            if (!act[c]) continue;
            if (cur[c].is_wr) begin
                if (ph[c] == 0 && r[4]) ph[c] = 1;
                else if (ph[c] == 1 && r[3]) begin
                    if (beat[c] == int'(cur[c].len)) ph[c] = 2;
                    else beat[c]++;
                end else if (ph[c] == 2 && r[1]) begin
                    n_checks++;
                    if (br !== m_bresp) begin
                        n_errors++;
                        $display("FAIL bresp cache%0d got %b want %b", c, br, m_bresp);
                    end
                    act[c] = 1'b0;
                end
            end else begin
                if (ph[c] == 0 && r[2]) ph[c] = 1;
                else if (ph[c] == 1 && rre[c] && r[0]) begin
                    n_checks++;
                    if ({rd, rl} !== {cur[c].addr + 32'(beat[c]), beat[c] == int'(cur[c].len)}) begin
                        n_errors++;
                        $display("FAIL rbeat cache%0d beat=%0d got data=%h last=%b want data=%h last=%b", c, beat[c],
                                 rd, rl, cur[c].addr + 32'(beat[c]), beat[c] == int'(cur[c].len));
                    end
                    if (beat[c] == int'(cur[c].len)) act[c] = 1'b0;
                    else beat[c]++;
                end
            end
        end

        // model: a free port goes to a requester next cycle; a tie follows the priority rule
        if (!e_busy) begin
            pi = awv[0] | arv[0];
            pd = awv[1] | arv[1];
            if (pi || pd) begin
                if (pi && pd) w = RR ? !e_last : 1'b1;
                else w = pd;
                e_busy = 1'b1; e_own = w; e_last = w;
            end
        end else if (done) begin
            e_busy = 1'b0;
        end
    endtask

    task automatic run(input int stop_beat);
        int cyc;
        cyc = 0;
        while (1) begin
            if (stop_beat >= 0 && m_act && !m_wr && m_beat == stop_beat) break;
            if (cq0.size() == 0 && cq1.size() == 0 && !act[0] && !act[1] && !m_act && !e_busy) break;
            if (cyc >= 20000) begin
                n_checks++; n_errors++;
                $display("FAIL run_timeout after %0d cycles", cyc);
                break;
            end
            drive_all();
            #1;
            check_all();
            update_all();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic apply_reset();
        clear_state();
        rst_n = 1'b0;
        drive_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_order(input string name, input logic [1:0] exp_q[$]);
        n_checks++;
        if (glog.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL %s_count got %0d grants want %0d", name, glog.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (glog[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL %s[%0d] got grant=%b want %b", name, i, glog[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_state();
        rst_n = 1'b0;
        instr_bus.arvalid = 1'b1; data_bus.awvalid = 1'b1; data_bus.wvalid = 1'b1;
        instr_bus.rready = 1'b1; data_bus.bready = 1'b1;
        mem_bus.awready = 1'b1; mem_bus.wready = 1'b1; mem_bus.arready = 1'b1;
        mem_bus.bvalid = 1'b1; mem_bus.rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({grant, busy} !== 3'b000) begin
            n_errors++; $display("FAIL reset_grant got grant=%b busy=%b want 00 0", grant, busy);
        end
        n_checks++;
        if ({mem_bus.awvalid, mem_bus.wvalid, mem_bus.arvalid, mem_bus.bready, mem_bus.rready} !== 5'b0) begin
            n_errors++; $display("FAIL reset_m_axi got aw/w/ar/b/r=%b want 00000",
                {mem_bus.awvalid, mem_bus.wvalid, mem_bus.arvalid, mem_bus.bready, mem_bus.rready});
        end
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (srdy(c) !== 5'b0) begin
                n_errors++; $display("FAIL reset_cache%0d got %b want 00000", c, srdy(c));
            end
        end
        drive_all();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_instr_read();
        glog.delete();
        cq0.push_back('{1'b0, 32'h0000_1000, 8'd127, 1'b0});
        run(-1);
        check_order("instr_read", '{2'b01});
    endtask

    task automatic test_data_write();
        glog.delete();
        cq1.push_back('{1'b1, 32'h0000_2000, 8'd127, 1'b0});
        run(-1);
        check_order("data_write", '{2'b10});
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cq0.push_back('{1'b0, 32'h0000_4000, 8'd15, 1'b0});
        cq1.push_back('{1'b0, 32'h0000_5000, 8'd15, 1'b0});
        run(-1);
        check_order("simultaneous", '{2'b10, 2'b01});
    endtask

    task automatic test_rounds();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cq0.push_back('{1'b0, 32'h0001_0000 + 32'(i * 64), 8'd3, 1'b0});
            cq1.push_back('{1'b0, 32'h0002_0000 + 32'(i * 64), 8'd3, 1'b0});
        end
        run(-1);
        if (RR) check_order("rounds_rr", '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01});
        else    check_order("rounds_fixed", '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01});
    endtask

    task automatic test_early_wvalid();
        glog.delete();
        aw_hold = 5;
        cq1.push_back('{1'b1, 32'h0000_7000, 8'd7, 1'b1});
        run(-1);
        aw_hold = 0;
        check_order("early_wvalid", '{2'b10});
    endtask

    task automatic test_reset_mid_burst();
        glog.delete();
        cq0.push_back('{1'b0, 32'h0000_3000, 8'd127, 1'b0});
        run(40);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, busy, mem_bus.rready} !== 4'b0000) begin
            n_errors++;
            $display("FAIL mid_reset got grant=%b busy=%b rready=%b want 00 0 0", grant, busy, mem_bus.rready);
        end
        clear_state();
        drive_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({grant, busy} !== 3'b000) begin
            n_errors++; $display("FAIL post_reset_idle got grant=%b busy=%b want 00 0", grant, busy);
        end
        cq1.push_back('{1'b0, 32'h0000_6000, 8'd7, 1'b0});
        run(-1);
        check_order("post_reset", '{2'b10});
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            txn_t t;
            t.is_wr   = 1'($urandom % 2);
            t.addr    = {16'h00A0, 16'($urandom) & 16'hFFC0};
            t.len     = 8'($urandom_range(0, 15));
            t.early_w = 1'($urandom % 2);
            if (($urandom % 2) != 0) cq0.push_back(t);
            else cq1.push_back(t);
        end
        run(-1);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_state();
        @(posedge clk);
        #1;
        test_reset();
        test_instr_read();
        test_data_write();
        test_simultaneous();
        test_rounds();
        test_early_wvalid();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
